sprite_plotter: RTL
===================

Name: sprite_plotter

Overview:
- Pixel-write initiator for the 160x120, 3-bit-colour VGA pixel sink; drives its x/y/color/plot inputs one pixel per clock.
- On a start pulse it erases a SPRITE_W x SPRITE_W sprite at its old position, then draws the selected sprite frame at its new position.
- Sits between the game FSM (player/ghost movement) and the VGA pixel sink.

Parameters:
- SPRITE_W, 5, sprite edge length in pixels; frame size is SPRITE_W*SPRITE_W.
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are suppressed.
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are suppressed.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- old_x  in  8  top-left x of the sprite to erase.
- old_y  in  9  top-left y of the sprite to erase.
- new_x  in  8  top-left x of the sprite to draw.
- new_y  in  9  top-left y of the sprite to draw.
- sprite_sel  in  2  frame select (0 right, 1 left, 2 up, 3 down).
- erase_en  in  1  1 = run the erase pass.
- bg_color  in  3  colour used by the erase pass.
- x  out  8  pixel x to the sink.
- y  out  9  pixel y to the sink.
- color  out  3  pixel colour to the sink.
- plot  out  1  write strobe to the sink.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Clock is `clock`. Reset is synchronous and active-high.
- Reset: state IDLE; x=0, y=0, color=0, plot=0, busy=0, done=0; counters cleared. Reset mid-pass aborts immediately and no further plot is issued.
- On start in IDLE, latch all coordinates, sprite_sel, erase_en and bg_color. Inputs are ignored afterwards until IDLE.
- start outside IDLE is ignored and is not queued.
- Outputs are registered.
- FSM IDLE -> ERASE (erase_en=1) or DRAW (erase_en=0) -> DONE -> IDLE.
- ERASE: N=SPRITE_W^2 cycles, row-major (col fastest). Output x=old_x+col, y=old_y+row, color=bg_color.
- DRAW: N cycles, row-major. Output x=new_x+col, y=new_y+row, color=ROM[sprite_sel][row][col].
- plot=1 in every ERASE/DRAW cycle unless x>=SCREEN_W or y>=SCREEN_H; suppressed pixels still take their cycle.
- Sums are computed at full port width (8-bit x, 9-bit y) with no wrap. Example: old_x=158, col=4 gives x=162, so plot=0.
- DONE: one cycle; done=1, plot=0, busy=0 next cycle.
- Timing with start at cycle 0 and erase_en=1: plots on cycles 1..2N, done at 2N+1 (51 for SPRITE_W=5).
- Timing with erase_en=0: plots on cycles 1..N, done at N+1.
- start in the same cycle as done (state DONE) is ignored. start on the first IDLE cycle after DONE is accepted.
- plot=0 in IDLE and DONE.

Optional Feature:
- Macro: SPRITE_TRANSPARENT_EN.
- Defined: in DRAW, ROM colour 3'b000 is transparent, so plot=0 for those pixels and their cycle is still consumed. ERASE is unaffected.
- Undefined: black sprite pixels are plotted with color=0.

Decomposition:
- Package sprite_pkg holds:
  - SPRITE_W default.
  - Colour constants: BLACK=3'b000, YELLOW=3'b110, BLUE=3'b001.
  - FSM state enum: IDLE, ERASE, DRAW, DONE.
  - 4-frame sprite table constant.
- Sub-module sprite_rom: combinational lookup of (sprite_sel,row,col) -> 3-bit colour.
- Frame 0 rows: 01110 / 11111 / 11100 / 11111 / 01110, where 1=YELLOW and 0=BLACK.
- Frames 1-3 are frame 0 mirrored (left) or transposed (up, down).

Test Plan:
- Reset then idle: x=0, y=0, plot=0, busy=0, done=0 for 10 cycles.
- start with old=(10,20), new=(11,20), sel=0, erase_en=1, bg=0:
  - cycle 1 gives x=10, y=20, color=0, plot=1.
  - cycle 25 gives (14,24).
  - cycle 26 gives (11,20), color=0.
  - cycle 27 gives (12,20), color=6.
  - done at cycle 51. Exactly 50 plot pulses.
- erase_en=0, new=(0,0): first plot at cycle 1 is (0,0); done at cycle 26; 25 plots.
- new=(158,118): only the cols 0-1 / rows 0-1 pixels plot (4 plots). Every other cycle has plot=0, and done still arrives at cycle 26.
- start pulsed again at cycles 5 and 51: both ignored. The second pass starts only on a start at cycle 52.
- reset asserted at cycle 12 of a pass: plot=0 and state IDLE from cycle 13. With SPRITE_TRANSPARENT_EN, sel=0 at (0,0) gives exactly 19 plots.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite plotter: colours, FSM states and the 4-frame sprite table.
// Frame order: 0 right, 1 left, 2 up, 3 down; bit [SPRITE_W_DEFAULT-1] of each row is column 0.
package sprite_pkg;

    localparam int SPRITE_W_DEFAULT = 5;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] BLUE   = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Left is the right frame mirrored; down is it transposed; up is down flipped vertically.
    localparam logic [SPRITE_W_DEFAULT-1:0] SPRITE_TABLE [4][SPRITE_W_DEFAULT] = '{
        '{5'b01110, 5'b11111, 5'b11100, 5'b11111, 5'b01110},
        '{5'b01110, 5'b11111, 5'b00111, 5'b11111, 5'b01110},
        '{5'b01010, 5'b11011, 5'b11111, 5'b11111, 5'b01110},
        '{5'b01110, 5'b11111, 5'b11111, 5'b11011, 5'b01010}
    };

    function automatic logic [2:0] pixel_color(input logic lit);
        return lit ? YELLOW : BLACK;
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// Combinational sprite lookup: (frame, row, col) -> 3-bit colour.
// Coordinates outside the stored table read as BLACK.
module sprite_rom
    import sprite_pkg::*;
#(
    parameter int CW = 3
) (
    input  logic [1:0]    sel_i,
    input  logic [CW-1:0] row_i,
    input  logic [CW-1:0] col_i,
    output logic [2:0]    color_o
);

    localparam int BW = $clog2(SPRITE_W_DEFAULT);

    logic [SPRITE_W_DEFAULT-1:0] row_bits_s;
    logic [BW-1:0]               bit_idx_s;

    // Table read with column 0 stored in the row's most significant bit.
    always_comb begin
        row_bits_s = '0;
        bit_idx_s  = '0;
        color_o    = BLACK;
        if ((int'(row_i) < SPRITE_W_DEFAULT) && (int'(col_i) < SPRITE_W_DEFAULT)) begin
            row_bits_s = SPRITE_TABLE[sel_i][BW'(row_i)];
            bit_idx_s  = BW'(SPRITE_W_DEFAULT - 1) - BW'(col_i);
            color_o    = pixel_color(row_bits_s[bit_idx_s]);
        end else begin
            color_o    = BLACK;
        end
    end

endmodule

// File: rtl/sprite_plotter.sv
// Erase-then-draw sprite pixel initiator for a 160x120 3-bit VGA pixel sink, one pixel per clock.
// Optional SPRITE_TRANSPARENT_EN: black sprite pixels are skipped (plot=0) during the draw pass.
module sprite_plotter
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = SPRITE_W_DEFAULT,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] old_x,
    input  logic [8:0] old_y,
    input  logic [7:0] new_x,
    input  logic [8:0] new_y,
    input  logic [1:0] sprite_sel,
    input  logic       erase_en,
    input  logic [2:0] bg_color,
    output logic [7:0] x,
    output logic [8:0] y,
    output logic [2:0] color,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int            CW    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam logic [CW-1:0] LAST  = CW'(SPRITE_W - 1);
    localparam logic [8:0]    SCR_W = 9'(SCREEN_W);
    localparam logic [9:0]    SCR_H = 10'(SCREEN_H);

    state_e        state_q, state_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [7:0]    ox_q, ox_d;
    logic [8:0]    oy_q, oy_d;
    logic [7:0]    nx_q, nx_d;
    logic [8:0]    ny_q, ny_d;
    logic [1:0]    sel_q, sel_d;
    logic [2:0]    bg_q, bg_d;

    logic [7:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic [2:0]    color_q, color_d;
    logic          plot_q, plot_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [7:0]    base_x_s;
    logic [8:0]    base_y_s;
    logic [8:0]    sum_x_s;
    logic [9:0]    sum_y_s;
    logic          on_screen_s;
    logic [2:0]    rom_color_s;

    // The ROM is addressed with the next pixel so its colour lands in the output register.
    sprite_rom #(
        .CW (CW)
    ) u_rom (
        .sel_i   (sel_d),
        .row_i   (row_d),
        .col_i   (col_d),
        .color_o (rom_color_s)
    );

    // Next-state, raster counters and request latch.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        sel_d   = sel_q;
        bg_d    = bg_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ox_d    = old_x;
                    oy_d    = old_y;
                    nx_d    = new_x;
                    ny_d    = new_y;
                    sel_d   = sprite_sel;
                    bg_d    = bg_color;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = erase_en ? ERASE : DRAW;
                end else begin
                    state_d = IDLE;
                end
            end
            ERASE, DRAW: begin
                if ((row_q == LAST) && (col_q == LAST)) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = (state_q == ERASE) ? DRAW : DONE;
                end else if (col_q == LAST) begin
                    col_d   = '0;
                    row_d   = row_q + CW'(1);
                end else begin
                    col_d   = col_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pixel for the next cycle; sums are widened so off-screen pixels never wrap back on.
    always_comb begin
        base_x_s    = (state_d == ERASE) ? ox_d : nx_d;
        base_y_s    = (state_d == ERASE) ? oy_d : ny_d;
        sum_x_s     = {1'b0, base_x_s} + 9'(col_d);
        sum_y_s     = {1'b0, base_y_s} + 10'(row_d);
        on_screen_s = (sum_x_s < SCR_W) && (sum_y_s < SCR_H);
        x_d         = x_q;
        y_d         = y_q;
        color_d     = color_q;
        plot_d      = 1'b0;
        if (state_d == ERASE) begin
            x_d     = sum_x_s[7:0];
            y_d     = sum_y_s[8:0];
            color_d = bg_d;
            plot_d  = on_screen_s;
        end else if (state_d == DRAW) begin
            x_d     = sum_x_s[7:0];
            y_d     = sum_y_s[8:0];
            color_d = rom_color_s;
`ifdef SPRITE_TRANSPARENT_EN
            plot_d  = on_screen_s && (rom_color_s != BLACK);
`else
            plot_d  = on_screen_s;
`endif
        end else begin
            plot_d  = 1'b0;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and registered outputs; reset aborts any pass in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            ox_q    <= 8'd0;
            oy_q    <= 9'd0;
            nx_q    <= 8'd0;
            ny_q    <= 9'd0;
            sel_q   <= 2'd0;
            bg_q    <= 3'd0;
            x_q     <= 8'd0;
            y_q     <= 9'd0;
            color_q <= 3'd0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            sel_q   <= sel_d;
            bg_q    <= bg_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign color = color_q;
    assign plot  = plot_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
